// File: rtl/maze_game_ctrl_if.sv
// maze_game_ctrl_if: controller <-> carver/player/display signal bundle
interface maze_game_ctrl_if;
  logic         btn_new;
  logic [1:0]   speed_sel;
  logic         move_up;
  logic         move_down;
  logic         move_left;
  logic         move_right;
  logic         carve_finished;
  logic [3:0]   carve_fin_x;
  logic [3:0]   carve_fin_y;
  logic [255:0] maze_data;
  logic         carve_start;
  logic [4:0]   carve_width;
  logic [4:0]   carve_height;
  logic [25:0]  carve_slow_time;
  logic [3:0]   player_x;
  logic [3:0]   player_y;
  logic [3:0]   goal_x;
  logic [3:0]   goal_y;
  logic [2:0]   level;
  logic [2:0]   state;
  logic         win;
  logic [7:0]   timeout_cnt;
  modport master (
    input  btn_new, speed_sel, move_up, move_down, move_left, move_right,
           carve_finished, carve_fin_x, carve_fin_y, maze_data,
    output carve_start, carve_width, carve_height, carve_slow_time,
           player_x, player_y, goal_x, goal_y, level, state, win, timeout_cnt
  );
  modport slave (
    output btn_new, speed_sel, move_up, move_down, move_left, move_right,
           carve_finished, carve_fin_x, carve_fin_y, maze_data,
    input  carve_start, carve_width, carve_height, carve_slow_time,
           player_x, player_y, goal_x, goal_y, level, state, win, timeout_cnt
  );
endinterface

// File: rtl/maze_game_ctrl.sv
// maze_game_ctrl: level/carve/play/win sequencer for the maze game (optional CARVE_TIMEOUT_EN adds a carve watchdog)
module maze_game_ctrl #(
  parameter int unsigned WIN_HOLD    = 50_000_000,
  parameter logic [25:0] CARVE_LIMIT = 26'h3FF_FFFF
) (
  input logic clk,
  input logic rst_n,
  maze_game_ctrl_if.master bus
);
  typedef enum logic [2:0] {IDLE, START, ARM, CARVE, PLAY, WIN} state_t;
  state_t st, st_n;
  logic [2:0] level_n;
  logic [3:0] px_n, py_n, gx_n, gy_n;
  logic [25:0] slow_n;
  logic [31:0] hold_cnt, hold_n;
  logic win_n, mv, ok, tmo;
  logic [4:0] tx, ty;
  assign bus.state = st;
  assign bus.carve_start = st == START;
  assign bus.carve_width = 5'd6 + {1'b0, bus.level, 1'b0};
  assign bus.carve_height = bus.carve_width;
`ifdef CARVE_TIMEOUT_EN
  logic [25:0] tmo_cnt;
  logic [7:0] tmo_total;
  logic carving;
  assign carving = st == ARM || st == CARVE;
  assign tmo = carving && tmo_cnt + 26'd1 >= CARVE_LIMIT && !bus.btn_new && !(st == CARVE && bus.carve_finished);
  assign bus.timeout_cnt = tmo_total;
  // watchdog: counts ARM+CARVE cycles, tallies expiries with saturation
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tmo_cnt <= '0;
      tmo_total <= '0;
    end else begin
      tmo_cnt <= carving && !tmo && !bus.btn_new ? tmo_cnt + 26'd1 : 26'd0;
      tmo_total <= tmo && tmo_total != 8'hFF ? tmo_total + 8'd1 : tmo_total;
    end
`else
  assign tmo = 1'b0;
  assign bus.timeout_cnt = '0;
`endif
  // candidate move: one pulse honoured per cycle, up > left > down > right
  always_comb begin
    tx = {1'b0, bus.player_x};
    ty = {1'b0, bus.player_y};
    mv = 1'b0;
    if (bus.move_up) begin
      mv = bus.player_y != 4'd0;
      ty = ty - 5'd1;
    end else if (bus.move_left) begin
      mv = bus.player_x != 4'd0;
      tx = tx - 5'd1;
    end else if (bus.move_down) begin
      mv = 1'b1;
      ty = ty + 5'd1;
    end else if (bus.move_right) begin
      mv = 1'b1;
      tx = tx + 5'd1;
    end
    ok = mv && tx < bus.carve_width && ty < bus.carve_height && bus.maze_data[{ty[3:0], tx[3:0]}];
  end
  // next state and next datapath values; a new-game request overrides everything
  always_comb begin
    st_n = st;
    level_n = bus.level;
    px_n = bus.player_x;
    py_n = bus.player_y;
    gx_n = bus.goal_x;
    gy_n = bus.goal_y;
    slow_n = bus.carve_slow_time;
    hold_n = 32'd0;
    win_n = 1'b0;
    if (bus.btn_new) begin
      st_n = START;
      level_n = 3'd0;
    end else if (tmo) st_n = START;
    else
      case (st)
        START: begin
          st_n = ARM;
          slow_n = bus.speed_sel == 2'd0 ? 26'd0 : bus.speed_sel == 2'd1 ? 26'd1_000 :
                   bus.speed_sel == 2'd2 ? 26'd100_000 : 26'd5_000_000;
        end
        ARM: st_n = bus.carve_finished ? ARM : CARVE;
        CARVE:
          if (bus.carve_finished) begin
            st_n = PLAY;
            gx_n = bus.carve_fin_x;
            gy_n = bus.carve_fin_y;
            px_n = 4'd0;
            py_n = 4'd0;
          end
        PLAY:
          if (bus.player_x == bus.goal_x && bus.player_y == bus.goal_y) begin
            st_n = WIN;
            win_n = 1'b1;
          end else if (ok) begin
            px_n = tx[3:0];
            py_n = ty[3:0];
          end
        WIN:
          if (hold_cnt + 32'd1 >= WIN_HOLD) begin
            st_n = START;
            level_n = bus.level == 3'd5 ? 3'd0 : bus.level + 3'd1;
          end else hold_n = hold_cnt + 32'd1;
        IDLE: st_n = IDLE;
        default: st_n = IDLE;
      endcase
  end
  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= IDLE;
      bus.level <= '0;
      bus.player_x <= '0;
      bus.player_y <= '0;
      bus.goal_x <= '0;
      bus.goal_y <= '0;
      bus.carve_slow_time <= '0;
      bus.win <= 1'b0;
      hold_cnt <= '0;
    end else begin
      st <= st_n;
      bus.level <= level_n;
      bus.player_x <= px_n;
      bus.player_y <= py_n;
      bus.goal_x <= gx_n;
      bus.goal_y <= gy_n;
      bus.carve_slow_time <= slow_n;
      bus.win <= win_n;
      hold_cnt <= hold_n;
    end
endmodule

// File: tb/tb_maze_game_ctrl.sv
// tb_maze_game_ctrl: directed checks of the maze game controller
module tb_maze_game_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  maze_game_ctrl_if bus();
  maze_game_ctrl #(.WIN_HOLD(4), .CARVE_LIMIT(26'd100)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_move(input logic [3:0] m);
    {bus.move_up, bus.move_left, bus.move_down, bus.move_right} = m;
    tick();
    {bus.move_up, bus.move_left, bus.move_down, bus.move_right} = 4'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic test_reset();
    #2;
    chk("rst_state", 32'(bus.state), 0);
    chk("rst_level", 32'(bus.level), 0);
    chk("rst_carve_start", 32'(bus.carve_start), 0);
    chk("rst_win", 32'(bus.win), 0);
    chk("rst_dims", {bus.carve_width, bus.carve_height}, {5'd6, 5'd6});
    chk("rst_slow", 32'(bus.carve_slow_time), 0);
    chk("rst_pos", {bus.player_x, bus.player_y, bus.goal_x, bus.goal_y}, 0);
    chk("rst_timeouts", 32'(bus.timeout_cnt), 0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_hold", 32'(bus.state), 0);
  endtask

  task automatic test_start_carve();
    bus.speed_sel = 2'd2;
    bus.carve_finished = 1'b1;
    bus.btn_new = 1'b1;
    tick();
    bus.btn_new = 1'b0;
    chk("start_state", 32'(bus.state), 1);
    chk("start_pulse", 32'(bus.carve_start), 1);
    chk("start_width", 32'(bus.carve_width), 6);
    tick();
    chk("arm_state", 32'(bus.state), 2);
    chk("arm_pulse_low", 32'(bus.carve_start), 0);
    chk("slow_sampled", 32'(bus.carve_slow_time), 100_000);
    tick();
    chk("arm_waits", 32'(bus.state), 2);
    bus.carve_finished = 1'b0;
    tick();
    chk("carve_state", 32'(bus.state), 3);
    bus.speed_sel = 2'd3;
    for (int i = 0; i < 40; i++) tick();
    chk("carve_waits", 32'(bus.state), 3);
    chk("slow_held", 32'(bus.carve_slow_time), 100_000);
    bus.carve_fin_x = 4'd3;
    bus.carve_fin_y = 4'd4;
    bus.carve_finished = 1'b1;
    tick();
    chk("play_state", 32'(bus.state), 4);
    chk("goal", {bus.goal_x, bus.goal_y}, {4'd3, 4'd4});
    chk("player_origin", {bus.player_x, bus.player_y}, 0);
  endtask

  task automatic test_moves();
    bus.maze_data = '0;
    bus.maze_data[0] = 1'b1;
    pulse_move(4'b0001);
    chk("right_closed", {bus.player_x, bus.player_y}, {4'd0, 4'd0});
    pulse_move(4'b0100);
    chk("left_edge", {bus.player_x, bus.player_y}, {4'd0, 4'd0});
    bus.maze_data[1] = 1'b1;
    pulse_move(4'b0001);
    chk("right_open", {bus.player_x, bus.player_y}, {4'd1, 4'd0});
    pulse_move(4'b1000);
    chk("up_edge", {bus.player_x, bus.player_y}, {4'd1, 4'd0});
    bus.maze_data[17] = 1'b1;
    pulse_move(4'b0010);
    chk("down_open", {bus.player_x, bus.player_y}, {4'd1, 4'd1});
    bus.maze_data[18] = 1'b1;
    pulse_move(4'b1001);
    chk("up_over_right", {bus.player_x, bus.player_y}, {4'd1, 4'd0});
  endtask

  task automatic test_win();
    bus.maze_data[2] = 1'b1;
    bus.maze_data[3] = 1'b1;
    bus.maze_data[19] = 1'b1;
    bus.maze_data[35] = 1'b1;
    bus.maze_data[51] = 1'b1;
    bus.maze_data[67] = 1'b1;
    pulse_move(4'b0001);
    pulse_move(4'b0001);
    for (int i = 0; i < 4; i++) pulse_move(4'b0010);
    chk("at_goal", {bus.player_x, bus.player_y, 3'(bus.state), bus.win}, {4'd3, 4'd4, 3'd4, 1'b0});
    tick();
    chk("win_enter", {3'(bus.state), bus.win}, {3'd5, 1'b1});
    pulse_move(4'b0100);
    chk("win_once", 32'(bus.win), 0);
    chk("win_no_move", {bus.player_x, bus.player_y}, {4'd3, 4'd4});
    tick();
    tick();
    chk("win_hold", {3'(bus.state), bus.level}, {3'd5, 3'd0});
    tick();
    chk("next_level", {3'(bus.state), bus.level, bus.carve_start}, {3'd1, 3'd1, 1'b1});
    chk("next_dims", {bus.carve_width, bus.carve_height}, {5'd8, 5'd8});
  endtask

  task automatic test_abort();
    tick();
    bus.carve_finished = 1'b0;
    tick();
    bus.carve_fin_x = 4'd0;
    bus.carve_fin_y = 4'd0;
    bus.carve_finished = 1'b1;
    tick();
    chk("quick_play", 32'(bus.state), 4);
    tick();
    chk("quick_win", {3'(bus.state), bus.win, bus.level}, {3'd5, 1'b1, 3'd1});
    bus.btn_new = 1'b1;
    tick();
    bus.btn_new = 1'b0;
    chk("abort", {3'(bus.state), bus.level, bus.carve_width}, {3'd1, 3'd0, 5'd6});
  endtask

`ifdef CARVE_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    tick();
    bus.carve_finished = 1'b0;
    while (bus.state != 3'd1 && n < 200) begin
      tick();
      n++;
    end
    chk("timeout_cycles", 32'(n), 100);
    chk("timeout_cnt", 32'(bus.timeout_cnt), 1);
    bus.carve_finished = 1'b1;
  endtask
`endif

  task automatic test_reset_mid();
    tick();
    tick();
    bus.carve_finished = 1'b0;
    tick();
    chk("pre_rst_carve", 32'(bus.state), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", {3'(bus.state), bus.level, bus.carve_slow_time}, 0);
    chk("async_rst_dims", 32'(bus.carve_width), 6);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("post_rst_idle", 32'(bus.state), 0);
  endtask

  initial begin
    bus.btn_new = 1'b0;
    bus.speed_sel = 2'd0;
    {bus.move_up, bus.move_left, bus.move_down, bus.move_right} = 4'b0;
    bus.carve_finished = 1'b0;
    bus.carve_fin_x = 4'd0;
    bus.carve_fin_y = 4'd0;
    bus.maze_data = '0;
    test_reset();
    test_start_carve();
    test_moves();
    test_win();
    test_abort();
`ifdef CARVE_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
